// File: rtl/display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display with a minimum on-screen hold.
// Grant/Active/BCD are registered; the owner's digits reach BCD on the same edge the grant does.
module display_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [15:0] Data0,
  input  logic [15:0] Data1,
  input  logic [15:0] Data2,
  input  logic [15:0] Data3,
  output logic [3:0]  Grant,
  output logic        Active,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0
);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_grant;
  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_ptr;
  logic [15:0]      r_bcd;

  state_t           w_state_nxt;
  logic [3:0]       w_grant_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_ptr_nxt;
  logic [3:0]       w_mask;
  logic [1:0]       w_pick;
  logic             w_issue;
  logic             w_owner_req;
  logic [15:0]      w_bcd_nxt;

  // First set bit of mask at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    f_rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) f_rr_pick = idx;
    end
  endfunction

  assign w_owner_req = |(Req & r_grant);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_mask      = Req;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|Req) w_issue = 1'b1;
      end
      ST_HOLD: begin
        if (!w_owner_req) begin
          if (|Req) begin
            w_issue = 1'b1;
          end else begin
            w_grant_nxt = 4'h0;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (|(Req & ~r_grant)) begin
          // Hold expired with competition: rotate away from the current owner.
          w_mask  = Req & ~r_grant;
          w_issue = 1'b1;
        end else begin
          w_cnt_nxt = LP_RELOAD;
        end
      end
      default: begin
        w_grant_nxt = 4'h0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_pick = f_rr_pick(w_mask, r_ptr);
    if (w_issue) begin
      w_grant_nxt = 4'b0001 << w_pick;
      w_cnt_nxt   = LP_RELOAD;
      w_ptr_nxt   = w_pick + 2'd1;
      w_state_nxt = ST_HOLD;
    end
  end

  always_comb begin
    w_bcd_nxt = r_bcd;
    case (w_grant_nxt)
      4'b0001: w_bcd_nxt = Data0;
      4'b0010: w_bcd_nxt = Data1;
      4'b0100: w_bcd_nxt = Data2;
      4'b1000: w_bcd_nxt = Data3;
      default: w_bcd_nxt = r_bcd;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= 4'h0;
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_ptr    <= 2'd0;
      r_bcd    <= 16'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_active <= |w_grant_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_bcd    <= w_bcd_nxt;
    end
  end

  assign Grant  = r_grant;
  assign Active = r_active;
  assign BCD3   = r_bcd[15:12];
  assign BCD2   = r_bcd[11:8];
  assign BCD1   = r_bcd[7:4];
  assign BCD0   = r_bcd[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboarded bench: two arbiters (hold 4 and hold 1) share stimulus and are checked
// every cycle against a counting-up reference model of ownership.
module tb_display_arbiter;

  typedef struct packed {
    logic [3:0]  g;
    logic        a;
    logic [15:0] b;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Req = 4'h0;
  logic [15:0] data [4];

  logic [3:0]  g4, g1;
  logic        a4, a1;
  logic [3:0]  b4_3, b4_2, b4_1, b4_0, b1_3, b1_2, b1_1, b1_0;

  int checks = 0;
  int failures = 0;

  int          m_hold  [2] = '{4, 1};
  int          m_owner [2];
  int          m_ptr   [2];
  int          m_age   [2];
  logic [15:0] m_bcd   [2];

  exp_t q [2][$];
  exp_t e;

  always #5 Clk = ~Clk;

  display_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .Data0(data[0]), .Data1(data[1]), .Data2(data[2]), .Data3(data[3]),
    .Grant(g4), .Active(a4), .BCD3(b4_3), .BCD2(b4_2), .BCD1(b4_1), .BCD0(b4_0)
  );

  display_arbiter #(.HOLD_CYCLES(1), .CNT_W(4)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .Data0(data[0]), .Data1(data[1]), .Data2(data[2]), .Data3(data[3]),
    .Grant(g1), .Active(a1), .BCD3(b1_3), .BCD2(b1_2), .BCD1(b1_1), .BCD0(b1_0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t dut_out(input int d);
    exp_t r;
    if (d == 0) r = '{g: g4, a: a4, b: {b4_3, b4_2, b4_1, b4_0}};
    else        r = '{g: g1, a: a1, b: {b1_3, b1_2, b1_1, b1_0}};
    return r;
  endfunction

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_age[d] = 0; m_bcd[d] = 16'h0;
      q[d].delete();
    end
  endtask

  // age = cycles the current owner has been on screen, including the coming one.
  task automatic model_step(input int d, input logic [3:0] rq);
    int nxt;
    logic [3:0] others;
    nxt = -2;
    if (m_owner[d] < 0) begin
      if (rq != 0) nxt = pick(rq, m_ptr[d]);
    end else if (!rq[m_owner[d]]) begin
      if (rq != 0) nxt = pick(rq, m_ptr[d]);
      else m_owner[d] = -1;
    end else if (m_age[d] < m_hold[d]) begin
      m_age[d]++;
    end else begin
      others = rq;
      others[m_owner[d]] = 1'b0;
      if (others != 0) nxt = pick(others, m_ptr[d]);
      else m_age[d] = 1;
    end
    if (nxt >= 0) begin
      m_owner[d] = nxt; m_age[d] = 1; m_ptr[d] = (nxt + 1) % 4;
    end
    if (m_owner[d] >= 0) m_bcd[d] = data[m_owner[d]];
    q[d].push_back('{g: (m_owner[d] < 0) ? 4'h0 : (4'h1 << m_owner[d]),
                     a: (m_owner[d] >= 0), b: m_bcd[d]});
  endtask

  task automatic cycle(input logic [3:0] rq, input bit rnd);
    @(negedge Clk);
    if (Reset) begin
      Reset = 1'b0;
      model_reset();
    end
    if (rnd) for (int i = 0; i < 4; i++) data[i] = 16'($urandom);
    Req = rq;
    model_step(0, rq);
    model_step(1, rq);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      e = dut_out(d);
      chk({tag, "_grant"}, 32'(e.g), 32'h0);
      chk({tag, "_active"}, 32'(e.a), 32'h0);
      chk({tag, "_bcd"}, 32'(e.b), 32'h0);
    end
  endtask

  task automatic mid_reset();
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
  endtask

  always @(posedge Clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() > 0) begin
        exp_t x, y;
        x = q[d].pop_front();
        y = dut_out(d);
        chk((d == 0) ? "h4_grant" : "h1_grant", 32'(y.g), 32'(x.g));
        chk((d == 0) ? "h4_active" : "h1_active", 32'(y.a), 32'(x.a));
        chk((d == 0) ? "h4_bcd" : "h1_bcd", 32'(y.b), 32'(x.b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rq;
    for (int i = 0; i < 4; i++) data[i] = 16'h0;
    model_reset();
    #1;
    check_reset_outputs("reset");

    // Single requester 1 with known digits.
    data[1] = 16'h1234;
    repeat (3) cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);

    // All requesting: full rotation several times.
    mid_reset();
    repeat (24) cycle(4'hF, 1'b1);

    // Owner 0 drops after 2 cycles while requester 2 waits.
    mid_reset();
    repeat (2) cycle(4'b0101, 1'b1);
    repeat (4) cycle(4'b0100, 1'b1);

    // Lone requester 3 re-arms, then releases; digits must hold.
    repeat (10) cycle(4'b1000, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1);

    // Two requesters alternating with changing digits.
    repeat (10) cycle(4'b0101, 1'b1);

    // Reset while requester 2 holds.
    repeat (2) cycle(4'b0100, 1'b1);
    mid_reset();

    rq = 4'h0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
      cycle(rq, $urandom_range(0, 1) == 1);
      if (n % 120 == 119) mid_reset();
    end
    cycle(4'h0, 1'b0);

    @(posedge Clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
